// File: rtl/microbot_motor_driver_pkg.sv
// Shared encodings for the microbot motor driver: channel states, direction
// and motor_cmd bit positions (bit-compatible with the navigation FSM word).
package microbot_motor_driver_pkg;

   localparam logic [1:0] ST_OFF  = 2'd0;
   localparam logic [1:0] ST_DEAD = 2'd1;
   localparam logic [1:0] ST_RAMP = 2'd2;
   localparam logic [1:0] ST_RUN  = 2'd3;

   typedef enum logic {
      DIR_FWD = 1'b0,
      DIR_REV = 1'b1
   } dir_t;

   localparam int unsigned A_FWD = 3;
   localparam int unsigned A_REV = 2;
   localparam int unsigned B_FWD = 1;
   localparam int unsigned B_REV = 0;

endpackage

// File: rtl/microbot_motor_channel.sv
// One H-bridge channel: dead-time on reversal, soft-start ramp, PWM gating
// and registered bridge drive. Instantiated once per motor.
module microbot_motor_channel
   import microbot_motor_driver_pkg::*;
#(
   parameter int unsigned DEAD_CYCLES = 16,
   parameter int unsigned RAMP_DIV    = 256,
   parameter int unsigned RAMP_STEP   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic       fwd,
   input  logic       rev,
   input  logic [7:0] duty,
   input  logic [7:0] pwm_cnt,
   output logic [1:0] drive,
   output logic       busy,
   output logic       fault
);

   localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   logic [1:0]    state_q, state_d;
   dir_t          dir_q, dir_d;
   logic [DW-1:0] dead_q, dead_d;
   logic [RW-1:0] div_q, div_d;
   logic [7:0]    cur_q, cur_d;
   logic [8:0]    ramp_sum;
   logic [1:0]    drive_d;
   logic          busy_d, fault_d;
   logic          cmd_fwd, cmd_rev, cmd_same, cmd_opp, pwm_on;

   always_comb begin
      cmd_fwd  = fwd & ~rev;
      cmd_rev  = rev & ~fwd;
      cmd_same = (dir_q == DIR_FWD) ? cmd_fwd : cmd_rev;
      cmd_opp  = (dir_q == DIR_FWD) ? cmd_rev : cmd_fwd;
      ramp_sum = {1'b0, cur_q} + 9'(RAMP_STEP);

      state_d = state_q;
      dir_d   = dir_q;
      dead_d  = dead_q;
      div_d   = div_q;
      cur_d   = cur_q;
      fault_d = fault | (ena & fwd & rev);

      if (!ena) begin
         state_d = ST_OFF;
         cur_d   = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               cur_d = '0;
               if (cmd_fwd | cmd_rev) begin
                  state_d = ST_RAMP;
                  dir_d   = cmd_fwd ? DIR_FWD : DIR_REV;
                  div_d   = '0;
               end
            end
            ST_DEAD: begin
               cur_d = '0;
               if (dead_q == '0) begin
                  if (cmd_fwd | cmd_rev) begin
                     state_d = ST_RAMP;
                     dir_d   = cmd_fwd ? DIR_FWD : DIR_REV;
                     div_d   = '0;
                  end else begin
                     state_d = ST_OFF;
                  end
               end else begin
                  dead_d = dead_q - 1'b1;
               end
            end
            default: begin
               // RAMP and RUN share command handling; ramp logic only runs when the command holds
               if (cmd_opp) begin
                  state_d = ST_DEAD;
                  dead_d  = DW'(DEAD_CYCLES - 1);
                  cur_d   = '0;
               end else if (!cmd_same) begin
                  state_d = ST_OFF;
                  cur_d   = '0;
               end else if (state_q == ST_RUN) begin
                  cur_d = duty;
               end else if (duty < cur_q) begin
                  cur_d   = duty;
                  state_d = ST_RUN;
               end else if (div_q == RW'(RAMP_DIV - 1)) begin
                  div_d = '0;
                  if (ramp_sum >= {1'b0, duty}) begin
                     cur_d   = duty;
                     state_d = ST_RUN;
                  end else begin
                     cur_d = ramp_sum[7:0];
                  end
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
         endcase
      end

      pwm_on = (pwm_cnt < cur_d);
      if ((state_d == ST_RAMP) || (state_d == ST_RUN)) begin
         drive_d = (dir_d == DIR_FWD) ? {pwm_on, 1'b0} : {1'b0, pwm_on};
      end else begin
         drive_d = 2'b00;
      end
      busy_d = (state_d == ST_DEAD) || (state_d == ST_RAMP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_OFF;
         dir_q   <= DIR_FWD;
         dead_q  <= '0;
         div_q   <= '0;
         cur_q   <= '0;
         drive   <= '0;
         busy    <= 1'b0;
         fault   <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         dead_q  <= dead_d;
         div_q   <= div_d;
         cur_q   <= cur_d;
         drive   <= drive_d;
         busy    <= busy_d;
         fault   <= fault_d;
      end
   end

endmodule

// File: rtl/microbot_motor_driver.sv
// Two-motor H-bridge driver: shared PWM timebase feeding two independent
// channels; output word matches the navigation FSM motor_cmd layout.
module microbot_motor_driver
   import microbot_motor_driver_pkg::*;
#(
   parameter int unsigned PRESCALE    = 4,
   parameter int unsigned DEAD_CYCLES = 16,
   parameter int unsigned RAMP_DIV    = 256,
   parameter int unsigned RAMP_STEP   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic [3:0] motor_cmd,
   input  logic [7:0] duty,
   output logic [3:0] drive_out,
   output logic [1:0] chan_busy,
   output logic [1:0] cmd_fault
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] prescaler;
   logic [7:0]    pwm_cnt;
   logic [1:0]    drive_a, drive_b;
   logic          busy_a, busy_b, fault_a, fault_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
         pwm_cnt   <= '0;
      end else if (prescaler == PW'(PRESCALE - 1)) begin
         prescaler <= '0;
         pwm_cnt   <= pwm_cnt + 1'b1;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   microbot_motor_channel #(
      .DEAD_CYCLES (DEAD_CYCLES),
      .RAMP_DIV    (RAMP_DIV),
      .RAMP_STEP   (RAMP_STEP)
   ) u_chan_a (
      .clk     (clk),
      .reset   (reset),
      .ena     (ena),
      .fwd     (motor_cmd[A_FWD]),
      .rev     (motor_cmd[A_REV]),
      .duty    (duty),
      .pwm_cnt (pwm_cnt),
      .drive   (drive_a),
      .busy    (busy_a),
      .fault   (fault_a)
   );

   microbot_motor_channel #(
      .DEAD_CYCLES (DEAD_CYCLES),
      .RAMP_DIV    (RAMP_DIV),
      .RAMP_STEP   (RAMP_STEP)
   ) u_chan_b (
      .clk     (clk),
      .reset   (reset),
      .ena     (ena),
      .fwd     (motor_cmd[B_FWD]),
      .rev     (motor_cmd[B_REV]),
      .duty    (duty),
      .pwm_cnt (pwm_cnt),
      .drive   (drive_b),
      .busy    (busy_b),
      .fault   (fault_b)
   );

   assign drive_out = {drive_a, drive_b};
   assign chan_busy = {busy_a, busy_b};
   assign cmd_fault = {fault_a, fault_b};

endmodule
